// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: converts a Q2.14 (x, y) pair into magnitude and
// atan2 angle (16384 = 90 deg), one micro-rotation per clock.
module cordic_vector #(
   parameter int DATA_WIDTH = 16,
   parameter int ITERATIONS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic [DATA_WIDTH-1:0] y_in,
   output logic [DATA_WIDTH-1:0] mag_out,
   output logic [DATA_WIDTH-1:0] angle_out,
   output logic                  done,
   output logic                  busy
);

   // x/y carry three extra bits: pre-rotation can reach +2.0 and the CORDIC
   // gain (~1.647) on a sqrt(2)-long vector needs headroom beyond that.
   localparam int XW = DATA_WIDTH + 3;
   localparam int IW = $clog2(DATA_WIDTH) + 1;
   localparam int PW = XW + 15;
   localparam logic [IW-1:0]         LAST_I  = IW'(ITERATIONS - 1);
   localparam logic signed [PW-1:0]  K_INV   = PW'(9949);
   localparam logic [DATA_WIDTH-1:0] QUARTER = DATA_WIDTH'(16384);
   localparam logic signed [PW-1:0]  MAG_MAX = PW'((1 << (DATA_WIDTH - 1)) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ITER  = 2'd1,
      SCALE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           i_q, i_d;
   logic signed [XW-1:0]    x_q, x_d;
   logic signed [XW-1:0]    y_q, y_d;
   logic [DATA_WIDTH-1:0]   z_q, z_d;
   logic                    zero_q, zero_d;
   logic [DATA_WIDTH-1:0]   mag_q, mag_d;
   logic [DATA_WIDTH-1:0]   ang_q, ang_d;
   logic                    done_q, done_d;

   // Micro-rotation angles atan(2^-i) in the 16384 = 90 deg format
   function automatic logic [DATA_WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
      int v;
      case (int'(idx))
         0:       v = 8192;
         1:       v = 4836;
         2:       v = 2555;
         3:       v = 1297;
         4:       v = 651;
         5:       v = 326;
         6:       v = 163;
         7:       v = 81;
         8:       v = 41;
         9:       v = 20;
         10:      v = 10;
         11:      v = 5;
         12:      v = 3;
         13:      v = 1;
         14:      v = 1;
         default: v = 0;
      endcase
      return DATA_WIDTH'(v);
   endfunction

   // Gain compensation (x * 0.60725) with truncation, clamped to [0, max positive]
   function automatic logic [DATA_WIDTH-1:0] scale_mag(input logic signed [XW-1:0] xv);
      logic signed [PW-1:0]  prod;
      logic [DATA_WIDTH-1:0] res;
      prod = (PW'(xv) * K_INV) >>> 14;
      if (prod[PW-1]) begin
         res = '0;
      end else if (prod > MAG_MAX) begin
         res = DATA_WIDTH'(MAG_MAX);
      end else begin
         res = DATA_WIDTH'(prod);
      end
      return res;
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start only matters in IDLE, so a busy start is dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ITER;
         ITER:    if (i_q == LAST_I) state_d = SCALE;
         SCALE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      busy = (state_q != IDLE);
   end

   // Datapath next values: capture with quadrant pre-rotation, iterate, scale
   always_comb begin
      logic signed [XW-1:0] xs, ys, x_sh, y_sh;
      i_d    = i_q;
      x_d    = x_q;
      y_d    = y_q;
      z_d    = z_q;
      zero_d = zero_q;
      mag_d  = mag_q;
      ang_d  = ang_q;
      done_d = 1'b0;
      xs     = XW'($signed(x_in));
      ys     = XW'($signed(y_in));
      x_sh   = x_q >>> i_q;
      y_sh   = y_q >>> i_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               i_d    = '0;
               zero_d = (x_in == '0) && (y_in == '0);
               // Left half-plane vectors are turned by +/-90 deg so the
               // iterations only need to cover +/-99.9 deg.
               if (!x_in[DATA_WIDTH-1]) begin
                  x_d = xs;
                  y_d = ys;
                  z_d = '0;
               end else if (!y_in[DATA_WIDTH-1]) begin
                  x_d = ys;
                  y_d = -xs;
                  z_d = QUARTER;
               end else begin
                  x_d = -ys;
                  y_d = xs;
                  z_d = -QUARTER;
               end
            end
         end
         ITER: begin
            if (!y_q[XW-1]) begin
               x_d = x_q + y_sh;
               y_d = y_q - x_sh;
               z_d = z_q + atan_lut(i_q);
            end else begin
               x_d = x_q - y_sh;
               y_d = y_q + x_sh;
               z_d = z_q - atan_lut(i_q);
            end
            i_d = (i_q == LAST_I) ? '0 : i_q + IW'(1);
         end
         SCALE: begin
            // A zero vector has no defined angle; report 0/0 explicitly
            if (zero_q) begin
               mag_d = '0;
               ang_d = '0;
            end else begin
               mag_d = scale_mag(x_q);
               ang_d = z_q;
            end
            done_d = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         i_q    <= '0;
         x_q    <= '0;
         y_q    <= '0;
         z_q    <= '0;
         zero_q <= 1'b0;
         mag_q  <= '0;
         ang_q  <= '0;
         done_q <= 1'b0;
      end else begin
         i_q    <= i_d;
         x_q    <= x_d;
         y_q    <= y_d;
         z_q    <= z_d;
         zero_q <= zero_d;
         mag_q  <= mag_d;
         ang_q  <= ang_d;
         done_q <= done_d;
      end
   end

   assign mag_out   = mag_q;
   assign angle_out = ang_q;
   assign done      = done_q;

endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed corner vectors plus random vectors
// compared against a real-arithmetic sqrt/atan2 model.
module tb_cordic_vector;

   localparam int  DW = 16;
   localparam real PI = 3.14159265358979323846;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] x_in;
   logic [DW-1:0] y_in;
   logic [DW-1:0] mag_out;
   logic [DW-1:0] angle_out;
   logic          done;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   cordic_vector #(.DATA_WIDTH(DW), .ITERATIONS(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .mag_out   (mag_out),
      .angle_out (angle_out),
      .done      (done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int s16(input logic [DW-1:0] v);
      return int'($signed(v));
   endfunction

   // Magnitude in Q2.14, clamped to the largest positive output code
   function automatic int ref_mag(input int x, input int y);
      real m;
      int  r;
      m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      r = int'(m);
      if (r > 32767) r = 32767;
      return r;
   endfunction

   // atan2 in the 16384 = 90 deg format; the zero vector maps to 0
   function automatic int ref_ang(input int x, input int y);
      real a;
      if (x == 0 && y == 0) return 0;
      a = $atan2(real'(y), real'(x)) * 32768.0 / PI;
      return int'(a);
   endfunction

   task automatic check(input string tag, input int obs, input int exp,
                        input int tol = 0, input bit wrap = 1'b0);
      int diff;
      diff = obs - exp;
      if (wrap) diff = int'($signed(16'(diff)));
      n_checks++;
      if (diff > tol || diff < -tol) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic check_result(input string tag, input int x, input int y,
                               input int mtol, input int atol);
      check({tag, " mag"}, s16(mag_out), ref_mag(x, y), mtol);
      check({tag, " ang"}, s16(angle_out), ref_ang(x, y), atol, 1'b1);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a vector with start for one edge
   task automatic launch(input int x, input int y);
      x_in  = 16'(x);
      y_in  = 16'(y);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Cycles until done is seen, or -1 if it never comes within the limit
   task automatic wait_done(input int limit, output int lat);
      int c;
      lat = -1;
      c   = 0;
      while (lat < 0 && c < limit) begin
         step();
         c++;
         if (done) lat = c;
      end
   endtask

   initial begin
      int lat;
      int extra;
      int dx[7] = '{16384, 0, 11585, -16384, -11585, 32767, 0};
      int dy[7] = '{0, 16384, 11585, 0, -11585, 32767, 0};
      int mt[7] = '{4, 4, 4, 4, 4, 0, 0};
      int at[7] = '{4, 4, 4, 4, 4, 4, 0};

      // Reset asserted together with start: reset wins
      rst   = 1'b1;
      start = 1'b1;
      x_in  = 16'd16384;
      y_in  = 16'd0;
      repeat (3) step();
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst mag", s16(mag_out), 0);
      check("rst ang", s16(angle_out), 0);
      rst   = 1'b0;
      start = 1'b0;
      step();
      check("idle busy", int'(busy), 0);

      // Directed corner vectors
      for (int k = 0; k < 7; k++) begin
         launch(dx[k], dy[k]);
         check($sformatf("dir%0d busy", k), int'(busy), 1);
         wait_done(40, lat);
         check($sformatf("dir%0d latency", k), lat, 17);
         check($sformatf("dir%0d busy at done", k), int'(busy), 0);
         check_result($sformatf("dir%0d", k), dx[k], dy[k], mt[k], at[k]);
         repeat (3) begin
            step();
            check($sformatf("dir%0d single pulse", k), int'(done), 0);
         end
         check_result($sformatf("dir%0d held", k), dx[k], dy[k], mt[k], at[k]);
      end

      // Start accepted in the done cycle
      launch(3000, 7000);
      wait_done(40, lat);
      check("b2b first latency", lat, 17);
      check_result("b2b first", 3000, 7000, 8, 8);
      launch(-9000, 4000);
      wait_done(40, lat);
      check("b2b second latency", lat, 17);
      check_result("b2b second", -9000, 4000, 8, 8);

      // Second start during a busy conversion is dropped
      launch(9000, -5000);
      repeat (4) step();
      x_in  = 16'(-20000);
      y_in  = 16'(12000);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(40, lat);
      check("repulse latency", lat, 12);
      extra = 0;
      repeat (30) begin
         step();
         if (done) extra++;
      end
      check("repulse extra done", extra, 0);
      check_result("repulse", 9000, -5000, 8, 8);

      // Reset in the middle of a conversion
      launch(-6000, -14000);
      repeat (7) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort done", int'(done), 0);
      check("abort busy", int'(busy), 0);
      check("abort mag", s16(mag_out), 0);
      check("abort ang", s16(angle_out), 0);
      wait_done(30, lat);
      check("abort no done", lat, -1);
      launch(-6000, -14000);
      wait_done(40, lat);
      check("after abort latency", lat, 17);
      check_result("after abort", -6000, -14000, 8, 8);

      // Random vectors of non-trivial length
      for (int r = 0; r < 24; r++) begin
         int rx, ry;
         do begin
            rx = int'($urandom_range(65535)) - 32768;
            ry = int'($urandom_range(65535)) - 32768;
         end while (longint'(rx) * rx + longint'(ry) * ry < 64'd16000000);
         launch(rx, ry);
         wait_done(40, lat);
         check($sformatf("rnd%0d latency", r), lat, 17);
         check_result($sformatf("rnd%0d (%0d,%0d)", r, rx, ry), rx, ry, 16, 24);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cordic_vector.md
CORDIC_VECTOR -- requirements
Module: cordic_vector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the width of the x/y inputs and magnitude/angle outputs.
REQ-002 SHALL have parameter ITERATIONS, default 16, giving the number of micro-rotations (1..DATA_WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port start, input, 1 bit: request to convert x_in/y_in, sampled only in IDLE.
REQ-006 SHALL have port x_in, input, DATA_WIDTH bits: signed Q2.14 x coordinate (16384 = 1.0).
REQ-007 SHALL have port y_in, input, DATA_WIDTH bits: signed Q2.14 y coordinate.
REQ-008 SHALL have port mag_out, output, DATA_WIDTH bits: signed Q2.14 magnitude sqrt(x^2+y^2), never negative.
REQ-009 SHALL have port angle_out, output, DATA_WIDTH bits: signed atan2(y,x), scaled so 16384 = 90 deg; -32768 represents +/-180 deg.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-011 SHALL have port busy, output, 1 bit: high while a conversion is in progress.

Function
REQ-012 SHALL implement a vectoring-mode CORDIC, the inverse of the team's rotation-mode sin/cos block, sharing its angle and data scaling.
REQ-013 SHALL use FSM states IDLE, ITER and SCALE, with transitions IDLE->ITER on start=1, ITER->SCALE after ITERATIONS iterations, and SCALE->IDLE unconditionally.
REQ-014 SHALL, on the IDLE edge where start=1, capture x_in/y_in with pre-rotation: x>=0 loads x,y,z=0; x<0,y>=0 loads x=y, y=-x, z=+16384; x<0,y<0 loads x=-y, y=x, z=-16384.
REQ-015 SHALL hold internal x/y registers DATA_WIDTH+3 bits signed and the z register DATA_WIDTH bits, with z wrapping modulo 2^DATA_WIDTH.
REQ-016 SHALL perform one iteration per ITER cycle with counter i = 0..ITERATIONS-1: if y>=0 then x+=y>>>i, y-=x>>>i, z+=atan_i; else x-=y>>>i, y+=x>>>i, z-=atan_i, all updates using pre-update values and arithmetic shifts.
REQ-017 SHALL define atan_i as the constant round(atan(2^-i)*32768/pi), so that atan_0=8192, atan_1=4836, atan_2=2555 and atan_3=1297.
REQ-018 SHALL, in SCALE, compute mag = (x * 9949) >>> 14 (gain compensation, K=0.60725) and saturate the result to 2^(DATA_WIDTH-1)-1.
REQ-019 SHALL register mag_out and angle_out=z on the SCALE edge and assert done=1 for exactly the following cycle.
REQ-020 SHALL have a latency where start sampled at edge N gives done=1 after edge N+ITERATIONS+1 (N+17 by default).
REQ-021 SHALL drive busy=1 in ITER and SCALE and busy=0 in IDLE.
REQ-022 SHALL ignore start while busy=1, without queueing it.
REQ-023 SHALL accept start on the edge where done=1, since the state is IDLE on that edge.
REQ-024 SHALL hold mag_out and angle_out stable between done pulses.
REQ-025 SHALL, when x_in=0 and y_in=0 are captured, output mag_out=0 and angle_out=0 regardless of the iteration results.

Reset
REQ-026 SHALL, on rst=1, force state=IDLE, i=0, internal x/y/z=0, mag_out=0, angle_out=0, done=0 and busy=0.
REQ-027 SHALL, when rst=1 arrives mid-conversion, abort the conversion with no done pulse.
REQ-028 SHALL give rst priority over start when both are asserted on the same edge.

Verification
REQ-029 SHALL cover (16384,0) -> mag 16384+/-4, angle 0+/-4, with done exactly 17 cycles after start.
REQ-030 SHALL cover (0,16384) -> angle 16384+/-4, and (11585,11585) -> mag 16384+/-4, angle 8192+/-4.
REQ-031 SHALL cover (-16384,0) -> angle -32768+/-4 modulo 2^16, and (-11585,-11585) -> angle -24576+/-4.
REQ-032 SHALL cover (32767,32767) -> mag_out saturated to 32767; (0,0) -> mag 0, angle 0.
REQ-033 SHALL cover start pulsed again at cycle 5 of a busy conversion -> ignored, exactly one done pulse, result matches the first inputs.
REQ-034 SHALL cover rst=1 at cycle 8 of a conversion -> no done, busy=0 and outputs 0 on the next cycle, and a following start then completes normally.
